// File: rtl/press_if.sv
// press_if: button-in / classified-event-out bundle between a press source and press_decoder
//   i_btn        de-chattered button level, 0 = pressed (driven by master)
//   o_pressed    1 while a press is being held (driven by slave)
//   o_short_p    one-cycle short-press pulse
//   o_long_p     one-cycle long-press pulse
//   o_dbl_p      one-cycle double-press pulse
//   o_press_cnt  saturating count of press edges
interface press_if #(parameter int CNT_W = 8);
   logic             i_btn;
   logic             o_pressed;
   logic             o_short_p;
   logic             o_long_p;
   logic             o_dbl_p;
   logic [CNT_W-1:0] o_press_cnt;
   modport master (output i_btn, input o_pressed, o_short_p, o_long_p, o_dbl_p, o_press_cnt);
   modport slave  (input i_btn, output o_pressed, o_short_p, o_long_p, o_dbl_p, o_press_cnt);
endinterface

// File: rtl/press_decoder.sv
// press_decoder: classifies de-chattered button presses as short, long or double and counts presses
//   i_clk  clock; every flop updates on the falling edge to line up with the chatter filter
//   i_rst  synchronous reset, active-low, sampled on the falling edge
//   bus    press_if slave: i_btn in; o_pressed, o_short_p, o_long_p, o_dbl_p, o_press_cnt out
module press_decoder #(
   parameter int LONG_CYC = 8,
   parameter int DBL_GAP  = 6,
   parameter int CNT_W    = 8
) (
   input logic    i_clk,
   input logic    i_rst,
   press_if.slave bus
);
   localparam int HW = $clog2(LONG_CYC + 1);
   localparam int GW = $clog2(DBL_GAP + 1);
   localparam logic [HW-1:0] L_MAX = HW'(LONG_CYC);
   localparam logic [GW-1:0] G_MAX = GW'(DBL_GAP);
   typedef enum logic [1:0] {IDLE, HELD, WAIT2, HELD2} state_t;
   state_t        r_state;
   logic          r_btn_d;
   logic [HW-1:0] r_hold;
   logic [GW-1:0] r_gap;
   logic          w_fall, w_rise;
   logic [HW-1:0] w_hold_inc;
   logic [GW-1:0] w_gap_inc;
   assign w_fall     = r_btn_d & ~bus.i_btn;
   assign w_rise     = ~r_btn_d & bus.i_btn;
   assign w_hold_inc = r_hold + 1'b1;
   assign w_gap_inc  = r_gap + 1'b1;
   always_ff @(negedge i_clk) begin
      if (!i_rst) begin
         r_state         <= IDLE;
         r_btn_d         <= 1'b1;
         r_hold          <= '0;
         r_gap           <= '0;
         bus.o_pressed   <= 1'b0;
         bus.o_short_p   <= 1'b0;
         bus.o_long_p    <= 1'b0;
         bus.o_dbl_p     <= 1'b0;
         bus.o_press_cnt <= '0;
      end else begin
         r_btn_d       <= bus.i_btn;
         bus.o_short_p <= 1'b0;
         bus.o_long_p  <= 1'b0;
         bus.o_dbl_p   <= 1'b0;
         if (w_fall && !(&bus.o_press_cnt))
            bus.o_press_cnt <= bus.o_press_cnt + 1'b1;
         case (r_state)
            IDLE:
               if (w_fall) begin
                  r_state       <= HELD;
                  r_hold        <= HW'(1);
                  bus.o_pressed <= 1'b1;
               end
            HELD:
               if (w_rise) begin
                  // a release after the long threshold already reported ends silently
                  r_state       <= (r_hold == L_MAX) ? IDLE : WAIT2;
                  r_gap         <= '0;
                  bus.o_pressed <= 1'b0;
               end else if (r_hold != L_MAX) begin
                  r_hold       <= w_hold_inc;
                  bus.o_long_p <= (w_hold_inc == L_MAX);
               end
            WAIT2: begin
               r_gap <= w_gap_inc;
               // a second press wins over gap expiry on the same edge
               if (w_fall) begin
                  r_state       <= HELD2;
                  bus.o_pressed <= 1'b1;
               end else if (w_gap_inc == G_MAX) begin
                  r_state       <= IDLE;
                  bus.o_short_p <= 1'b1;
               end
            end
            HELD2:
               if (w_rise) begin
                  r_state       <= IDLE;
                  bus.o_pressed <= 1'b0;
                  bus.o_dbl_p   <= 1'b1;
               end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_press_decoder.sv
// tb_press_decoder: directed press patterns checked every cycle against a timestamp-based press model
module tb_press_decoder;
   localparam int LONG = 8;
   localparam int DBL  = 6;
   logic clk, rst;
   press_if #(.CNT_W(8)) bus();
   press_decoder #(.LONG_CYC(LONG), .DBL_GAP(DBL), .CNT_W(8)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   int n_chk = 0, n_err = 0;
   int cyc = 0, edge_n = 0;
   int n_short = 0, n_long = 0, n_dbl = 0, last_short = 0, last_long = 0;
   bit armed = 0;
   logic m_prev, exp_pressed, exp_short, exp_long, exp_dbl;
   int m_cnt, m_mode, t_fall, t_rel;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, got, want);
      end
   endtask
   // model: phases 0 idle, 1 first press, 2 awaiting second press, 3 second press; timing from edge stamps
   always @(negedge clk) begin
      if (!rst) begin
         m_prev = 1'b1;
         m_mode = 0;
         m_cnt = 0;
         {exp_pressed, exp_short, exp_long, exp_dbl} = '0;
         armed = 1;
      end else begin
         logic f, r;
         f = m_prev & ~bus.i_btn;
         r = ~m_prev & bus.i_btn;
         m_prev = bus.i_btn;
         {exp_short, exp_long, exp_dbl} = '0;
         if (f && m_cnt < 255) m_cnt++;
         if (m_mode == 0) begin
            if (f) begin m_mode = 1; t_fall = edge_n; end
         end else if (m_mode == 1) begin
            if (r) begin
               if (edge_n - t_fall < LONG) begin m_mode = 2; t_rel = edge_n; end
               else m_mode = 0;
            end else if (edge_n - t_fall == LONG - 1) exp_long = 1;
         end else if (m_mode == 2) begin
            if (f) m_mode = 3;
            else if (edge_n - t_rel == DBL) begin exp_short = 1; m_mode = 0; end
         end else if (r) begin
            exp_dbl = 1;
            m_mode = 0;
         end
         exp_pressed = (m_mode == 1 || m_mode == 3);
      end
      edge_n++;
   end
   always @(posedge clk) begin
      cyc++;
      if (armed) begin
         chk("pressed", 32'(bus.o_pressed), 32'(exp_pressed));
         chk("short_p", 32'(bus.o_short_p), 32'(exp_short));
         chk("long_p", 32'(bus.o_long_p), 32'(exp_long));
         chk("dbl_p", 32'(bus.o_dbl_p), 32'(exp_dbl));
         chk("press_cnt", 32'(bus.o_press_cnt), 32'(m_cnt));
      end
      if (bus.o_short_p === 1'b1) begin n_short++; last_short = cyc; end
      if (bus.o_long_p === 1'b1) begin n_long++; last_long = cyc; end
      if (bus.o_dbl_p === 1'b1) n_dbl++;
   end
   task automatic drive(input logic v, input int n, output int t);
      @(posedge clk);
      #1 bus.i_btn = v;
      t = cyc;
      repeat (n - 1) @(posedge clk);
   endtask
   initial begin
      int t, tf, tr, s0;
      rst = 1'b0;
      bus.i_btn = 1'b1;
      repeat (3) @(posedge clk);
      chk("rst_cnt", 32'(bus.o_press_cnt), 0);
      chk("rst_pressed", 32'(bus.o_pressed), 0);
      #1 rst = 1'b1;
      // short press
      drive(0, 3, tf); drive(1, 10, tr);
      chk("short_count", n_short, 1);
      chk("short_latency", last_short - tr, DBL + 1);
      chk("short_no_long", n_long, 0);
      chk("short_no_dbl", n_dbl, 0);
      chk("short_cnt", 32'(bus.o_press_cnt), 1);
      // long press
      drive(0, 12, tf); drive(1, 10, tr);
      chk("long_count", n_long, 1);
      chk("long_latency", last_long - tf, LONG);
      chk("long_no_short", n_short, 1);
      chk("long_cnt", 32'(bus.o_press_cnt), 2);
      // double press
      drive(0, 3, t); drive(1, 2, t); drive(0, 3, t); drive(1, 10, t);
      chk("dbl_count", n_dbl, 1);
      chk("dbl_no_short", n_short, 1);
      chk("dbl_cnt", 32'(bus.o_press_cnt), 4);
      // second fall exactly on the expiry edge
      drive(0, 3, t); drive(1, DBL, t); drive(0, 3, t); drive(1, 10, t);
      chk("edge_dbl", n_dbl, 2);
      chk("edge_no_short", n_short, 1);
      // one cycle too late: two separate shorts
      drive(0, 3, t); drive(1, DBL + 1, t); drive(0, 3, t); drive(1, 10, t);
      chk("late_short", n_short, 3);
      chk("late_dbl", n_dbl, 2);
      chk("late_cnt", 32'(bus.o_press_cnt), 8);
      // reset mid-HELD with hold count at 5
      drive(0, 5, t);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      chk("midrst_cnt", 32'(bus.o_press_cnt), 0);
      chk("midrst_pressed", 32'(bus.o_pressed), 0);
      #1 rst = 1'b1;
      @(posedge clk);
      chk("redetect_cnt", 32'(bus.o_press_cnt), 1);
      chk("redetect_pressed", 32'(bus.o_pressed), 1);
      repeat (2) @(posedge clk);
      drive(1, 12, t);
      chk("redetect_short", n_short, 4);
      // saturation
      s0 = n_short;
      for (int i = 0; i < 260; i++) begin
         drive(0, 3, t); drive(1, 17, t);
      end
      chk("sat_cnt", 32'(bus.o_press_cnt), 255);
      chk("sat_shorts", n_short - s0, 260);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
